instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction-register path in the multicycle CPU.
- On a fetch request from the control unit, issues a word read to instruction memory and waits for a variable-latency ready handshake.
- Presents the fetched word to the instruction register, which samples on every CLK, and holds it stable until the next successful fetch.
- Flags misaligned addresses and memory timeouts.

Parameters:
- TIMEOUT, 16: maximum number of memReq-high cycles before a fetch is abandoned. Legal range is 2..255.
- CNT_W, 16: width of the completed-fetch counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- fetchReq  input  1  control unit requests a fetch of pcIn. Sampled only in IDLE.
- pcIn  input  32  byte address to fetch.
- flush  input  1  abandon any in-flight fetch.
- memReq  output  1  read request to instruction memory.
- memAddr  output  32  read address; stable while memReq=1.
- memRdata  input  32  read data; valid when memReady=1.
- memReady  input  1  memory completes the read this cycle. Ignored unless memReq=1.
- instrOut  output  32  last successfully fetched instruction. Feeds the instruction register dataIn.
- instrValid  output  1  one-cycle pulse: instrOut updated this cycle.
- fetchErr  output  1  one-cycle pulse: fetch failed (misaligned address or timeout).
- busy  output  1  high in WAIT.
- fetchCount  output  CNT_W  number of successful fetches; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and clears all state. Reset values: memReq=0, memAddr=0, instrOut=0, instrValid=0, fetchErr=0, busy=0, fetchCount=0, wait counter=0. Reset during WAIT drops memReq on the next edge and discards any response.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE:
  - fetchReq=1 and pcIn[1:0]==0 and flush=0: next cycle memAddr=pcIn, memReq=1, busy=1, wait counter=0, state WAIT.
  - fetchReq=1 and pcIn[1:0]!=0 and flush=0: next cycle fetchErr=1 for one cycle. No memory request. Stay IDLE. instrOut unchanged.
  - flush=1 in IDLE: no effect except that a simultaneous fetchReq is ignored.
- WAIT:
  - memReq stays high and memAddr is frozen until exit.
  - Incoming fetchReq is ignored; it is not queued.
  - memReady=1: next cycle instrOut=memRdata, instrValid=1, fetchCount+1 (wraps), memReq=0, busy=0, state IDLE.
  - memReady=0: the wait counter increments. If the counter equals TIMEOUT-1, then next cycle memReq=0, fetchErr=1, busy=0, state IDLE, and instrOut is unchanged. memReq is therefore high for exactly TIMEOUT cycles at most.
  - memReady=1 in the same cycle as the final timeout count: success wins.
  - flush=1 in WAIT: next cycle memReq=0, state IDLE, no instrValid, no fetchErr. A memReady in the same cycle is discarded, and instrOut and fetchCount are unchanged.
- Latency:
  - fetchReq at edge n gives memReq=1 after edge n.
  - memReady sampled at edge m gives instrValid=1 and the new instrOut after edge m.
  - With a zero-wait memory (memReady=1 in the first memReq cycle), instrValid asserts 2 cycles after fetchReq.
- instrValid and fetchErr are never high together and are each one cycle wide.
- Between fetches instrOut is constant, so the downstream register re-latches the same value.

Test Plan:
- Zero-wait fetch: Reset, then fetchReq with pcIn=0x0000_0040, and memReady=1 with memRdata=0x2008_0005 in the first memReq cycle. Required: memAddr=0x40; instrValid pulses 2 cycles after fetchReq; instrOut=0x2008_0005; fetchCount=1.
- Wait states with ignored request: memReady delayed 5 cycles, memRdata=0x8C09_0004, and a second fetchReq mid-WAIT. Required: memReq high exactly 5 cycles; the second request is ignored; one instrValid pulse; fetchCount=1 more than before the fetch.
- Misaligned address: fetchReq with pcIn=0x0000_0042. Required: memReq stays 0; fetchErr pulses one cycle; instrOut holds its previous value.
- Timeout: TIMEOUT=16 and memReady held 0. Required: memReq high exactly 16 cycles, then fetchErr pulses one cycle; back in IDLE. A retry with memReady=1 then succeeds.
- Flush against response: flush and memReady asserted in the same WAIT cycle with memRdata=0xFFFF_FFFF. Required: no instrValid; instrOut and fetchCount unchanged; memReq drops the next cycle.
- Reset and counter wrap: assert Reset during WAIT, which must clear all outputs on the next edge. Then with CNT_W=4, perform 17 successful fetches. Required: fetchCount=1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory on request,
// waits for a variable-latency ready, and presents the fetched word to the IR.
module instr_fetch_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             fetchReq,
    input  logic [31:0]      pcIn,
    input  logic             flush,
    output logic             memReq,
    output logic [31:0]      memAddr,
    input  logic [31:0]      memRdata,
    input  logic             memReady,
    output logic [31:0]      instrOut,
    output logic             instrValid,
    output logic             fetchErr,
    output logic             busy,
    output logic [CNT_W-1:0] fetchCount
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Count value reached in the last permitted memReq cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] waitCnt;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_IDLE;
            waitCnt    <= '0;
            memReq     <= 1'b0;
            memAddr    <= '0;
            instrOut   <= '0;
            instrValid <= 1'b0;
            fetchErr   <= 1'b0;
            busy       <= 1'b0;
            fetchCount <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; a branch below raises them for exactly one cycle.
            instrValid <= 1'b0;
            fetchErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetchReq && !flush) begin
                        if (pcIn[1:0] == 2'b00) begin
                            memAddr <= pcIn;
                            memReq  <= 1'b1;
                            busy    <= 1'b1;
                            waitCnt <= '0;
                            state   <= ST_WAIT;
                        end else begin
                            fetchErr <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Flush outranks a same-cycle response; a response outranks the timeout.
                    if (flush) begin
                        memReq <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (memReady) begin
                        instrOut   <= memRdata;
                        instrValid <= 1'b1;
                        fetchCount <= fetchCount + 1'b1;
                        memReq     <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (waitCnt == LAST_WAIT) begin
                        fetchErr <= 1'b1;
                        memReq   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: zero-wait, wait states, misalignment,
// timeout, flush against response, reset mid-fetch and counter wrap.
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             fetchReq;
    logic [31:0]      pcIn;
    logic             flush;
    logic             memReq;
    logic [31:0]      memAddr;
    logic [31:0]      memRdata;
    logic             memReady;
    logic [31:0]      instrOut;
    logic             instrValid;
    logic             fetchErr;
    logic             busy;
    logic [CNT_W-1:0] fetchCount;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .fetchReq   (fetchReq),
        .pcIn       (pcIn),
        .flush      (flush),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memRdata   (memRdata),
        .memReady   (memReady),
        .instrOut   (instrOut),
        .instrValid (instrValid),
        .fetchErr   (fetchErr),
        .busy       (busy),
        .fetchCount (fetchCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hi;
        Reset    = 1'b1;
        fetchReq = 1'b0;
        pcIn     = '0;
        flush    = 1'b0;
        memRdata = '0;
        memReady = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_instrOut", instrOut, 32'd0);
        check("rst_flags", {29'd0, instrValid, fetchErr, busy}, 32'd0);
        check("rst_count", 32'(fetchCount), 32'd0);

        // Zero-wait fetch
        fetchReq = 1'b1; pcIn = 32'h0000_0040;
        tick();
        fetchReq = 1'b0;
        check("zw_memReq", 32'(memReq), 32'd1);
        check("zw_memAddr", memAddr, 32'h40);
        check("zw_busy", 32'(busy), 32'd1);
        check("zw_noValidYet", 32'(instrValid), 32'd0);
        memReady = 1'b1; memRdata = 32'h2008_0005;
        tick();
        memReady = 1'b0;
        check("zw_valid", 32'(instrValid), 32'd1);
        check("zw_instr", instrOut, 32'h2008_0005);
        check("zw_count", 32'(fetchCount), 32'd1);
        check("zw_memReqDrop", 32'(memReq), 32'd0);
        tick();
        check("zw_validPulse", 32'(instrValid), 32'd0);
        check("zw_instrHold", instrOut, 32'h2008_0005);

        // Wait states, second request mid-WAIT ignored
        fetchReq = 1'b1; pcIn = 32'h0000_0100;
        tick();
        fetchReq = 1'b0;
        hi = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                fetchReq = 1'b1; pcIn = 32'h0000_0200;
            end else begin
                fetchReq = 1'b0;
            end
            tick();
            if (memReq) hi++;
            check("ws_addrFrozen", memAddr, 32'h100);
            check("ws_noValid", 32'(instrValid), 32'd0);
        end
        fetchReq = 1'b0;
        memReady = 1'b1; memRdata = 32'h8C09_0004;
        tick();
        memReady = 1'b0;
        check("ws_memReqCycles", 32'(hi), 32'd5);
        check("ws_valid", 32'(instrValid), 32'd1);
        check("ws_instr", instrOut, 32'h8C09_0004);
        check("ws_count", 32'(fetchCount), 32'd2);
        check("ws_memReqDrop", 32'(memReq), 32'd0);
        tick();
        check("ws_notQueued", 32'(memReq), 32'd0);
        check("ws_onePulse", 32'(instrValid), 32'd0);

        // Misaligned address
        fetchReq = 1'b1; pcIn = 32'h0000_0042;
        tick();
        fetchReq = 1'b0;
        check("mis_err", 32'(fetchErr), 32'd1);
        check("mis_memReq", 32'(memReq), 32'd0);
        check("mis_instrHold", instrOut, 32'h8C09_0004);
        tick();
        check("mis_errPulse", 32'(fetchErr), 32'd0);
        check("mis_memReq2", 32'(memReq), 32'd0);

        // Timeout with memReady held low
        fetchReq = 1'b1; pcIn = 32'h0000_0080;
        tick();
        fetchReq = 1'b0;
        hi = 0;
        for (int k = 0; k < 40 && memReq; k++) begin
            check("to_noErrEarly", 32'(fetchErr), 32'd0);
            hi++;
            tick();
        end
        check("to_memReqCycles", 32'(hi), 32'd16);
        check("to_err", 32'(fetchErr), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_instrHold", instrOut, 32'h8C09_0004);
        check("to_count", 32'(fetchCount), 32'd2);
        tick();
        check("to_errPulse", 32'(fetchErr), 32'd0);
        fetchReq = 1'b1; pcIn = 32'h0000_0084;
        tick();
        fetchReq = 1'b0;
        check("retry_memReq", 32'(memReq), 32'd1);
        memReady = 1'b1; memRdata = 32'h1234_5678;
        tick();
        memReady = 1'b0;
        check("retry_valid", 32'(instrValid), 32'd1);
        check("retry_instr", instrOut, 32'h1234_5678);
        check("retry_count", 32'(fetchCount), 32'd3);

        // Flush against a same-cycle response
        fetchReq = 1'b1; pcIn = 32'h0000_00C0;
        tick();
        fetchReq = 1'b0;
        tick();
        flush = 1'b1; memReady = 1'b1; memRdata = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0; memReady = 1'b0;
        check("fl_memReq", 32'(memReq), 32'd0);
        check("fl_flags", {30'd0, instrValid, fetchErr}, 32'd0);
        check("fl_instr", instrOut, 32'h1234_5678);
        check("fl_count", 32'(fetchCount), 32'd3);
        check("fl_busy", 32'(busy), 32'd0);

        // Reset during WAIT
        fetchReq = 1'b1; pcIn = 32'h0000_0010;
        tick();
        fetchReq = 1'b0;
        check("rw_memReq", 32'(memReq), 32'd1);
        Reset = 1'b1; memReady = 1'b1; memRdata = 32'hDEAD_BEEF;
        tick();
        Reset = 1'b0; memReady = 1'b0;
        check("rw_memReq0", 32'(memReq), 32'd0);
        check("rw_memAddr", memAddr, 32'd0);
        check("rw_instr", instrOut, 32'd0);
        check("rw_flags", {29'd0, instrValid, fetchErr, busy}, 32'd0);
        check("rw_count", 32'(fetchCount), 32'd0);

        // 17 successful fetches wrap a 4-bit counter to 1
        for (int i = 1; i <= 17; i++) begin
            fetchReq = 1'b1; pcIn = 32'(i * 4);
            tick();
            fetchReq = 1'b0;
            memReady = 1'b1; memRdata = 32'(i);
            tick();
            memReady = 1'b0;
            check("wrap_valid", 32'(instrValid), 32'd1);
        end
        check("wrap_count", 32'(fetchCount), 32'd1);
        check("wrap_instr", instrOut, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
